// File: rtl/mem_map_bus_arbiter_pkg.sv
// Shared definitions for the memory-map bus arbiter: FSM states, port ids and
// the default region map (dev i occupies bits [i*32 +: 32]).
package mem_map_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam int unsigned DFLT_ADDR_W = 32;
  localparam int unsigned DFLT_N_DEV  = 4;

  // Default map: d0 data RAM, d1 instruction ROM, d2 GPIO, d3 UART.
  localparam logic [DFLT_N_DEV*DFLT_ADDR_W-1:0] DFLT_DEV_BASE = {
    32'h1001_0108, 32'h1001_0100, 32'h0040_0000, 32'h1001_0000
  };
  localparam logic [DFLT_N_DEV*DFLT_ADDR_W-1:0] DFLT_DEV_LIMIT = {
    32'h1001_011F, 32'h1001_0107, 32'h0040_FFFF, 32'h1001_00FF
  };
  localparam logic [DFLT_N_DEV*DFLT_ADDR_W-1:0] DFLT_DEV_OFFS = '0;

endpackage

// File: rtl/mem_map_region_decode.sv
// Combinational region decoder.
// Ports:
//   addr_i      byte address to decode
//   hit_o       some region contains addr_i
//   sel_o       one-hot region select, lowest index wins on overlap
//   word_addr_o ((addr_i - BASE[i]) >> 2) + OFFS[i] for the selected region, else 0
module mem_map_region_decode
  import mem_map_bus_arbiter_pkg::*;
#(
  parameter int unsigned                   ADDR_W = DFLT_ADDR_W,
  parameter int unsigned                   N_DEV  = DFLT_N_DEV,
  parameter logic [N_DEV*ADDR_W-1:0]       BASE   = DFLT_DEV_BASE,
  parameter logic [N_DEV*ADDR_W-1:0]       LIMIT  = DFLT_DEV_LIMIT,
  parameter logic [N_DEV*ADDR_W-1:0]       OFFS   = DFLT_DEV_OFFS
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [N_DEV-1:0]  sel_o,
  output logic [ADDR_W-1:0] word_addr_o
);

  logic [N_DEV-1:0]  match;
  logic [ADDR_W-1:0] waddr [N_DEV];

  for (genvar i = 0; i < N_DEV; i++) begin : g_dev
    localparam logic [ADDR_W-1:0] B = BASE[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] L = LIMIT[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] O = OFFS[i*ADDR_W +: ADDR_W];

    assign match[i] = (addr_i >= B) && (addr_i <= L);
    // Only meaningful when match[i]; the subtraction never wraps in that case.
    assign waddr[i] = ((addr_i - B) >> 2) + O;

    // Lowest index has priority on overlapping regions.
    if (i == 0) begin : g_first
      assign sel_o[i] = match[i];
    end else begin : g_rest
      assign sel_o[i] = match[i] & ~(|match[i-1:0]);
    end
  end

  assign hit_o = |match;

  // One-hot select lets the word address be a plain AND-OR mux.
  always_comb begin
    word_addr_o = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (sel_o[i]) word_addr_o = word_addr_o | waddr[i];
    end
  end

endmodule

// File: rtl/mem_map_bus_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared device bus with a
// req/ack handshake, device wait states, timeout and error responses.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (read-only)
//   if_rdata/if_ack/if_err      fetch response (1-cycle ack pulse)
//   d_req/d_we/d_addr/d_wdata   data request
//   d_rdata/d_ack/d_err         data response (1-cycle ack pulse)
//   dev_sel/dev_we/dev_addr/dev_wdata  device bus, active only in ACCESS
//   dev_rdata/dev_ready         per-device read data and completion
module mem_map_bus_arbiter
  import mem_map_bus_arbiter_pkg::*;
#(
  parameter int unsigned             ADDR_W    = DFLT_ADDR_W,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             N_DEV     = DFLT_N_DEV,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE  = DFLT_DEV_BASE,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_LIMIT = DFLT_DEV_LIMIT,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_OFFS  = DFLT_DEV_OFFS,
  parameter logic [N_DEV-1:0]        DEV_RO    = '0,
  parameter int unsigned             TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic [DATA_W-1:0]       if_rdata,
  output logic                    if_ack,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [DATA_W-1:0]       d_wdata,
  output logic [DATA_W-1:0]       d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ready
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e             state_q;
  port_e              port_q;
  port_e              rr_last_q;
  logic [TMR_W-1:0]   timer_q;
  logic [DATA_W-1:0]  if_rdata_q, d_rdata_q;
  logic               if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [N_DEV-1:0]   dev_sel_q;
  logic               dev_we_q;
  logic [ADDR_W-1:0]  dev_addr_q;
  logic [DATA_W-1:0]  dev_wdata_q;

  // Grant selection: round-robin on a tie, otherwise whichever port asks.
  port_e              gnt_port_c;
  logic               gnt_valid_c;
  logic [ADDR_W-1:0]  gnt_addr_c;
  logic               gnt_we_c;
  logic [DATA_W-1:0]  gnt_wdata_c;

  always_comb begin
    gnt_valid_c = if_req | d_req;
    gnt_port_c  = PORT_D;
    if (if_req && d_req) begin
      gnt_port_c = (rr_last_q == PORT_D) ? PORT_IF : PORT_D;
    end else if (if_req) begin
      gnt_port_c = PORT_IF;
    end
    gnt_addr_c  = (gnt_port_c == PORT_IF) ? if_addr : d_addr;
    gnt_we_c    = (gnt_port_c == PORT_D) & d_we;
    gnt_wdata_c = (gnt_port_c == PORT_D) ? d_wdata : '0;
  end

  logic               dec_hit;
  logic [N_DEV-1:0]   dec_sel;
  logic [ADDR_W-1:0]  dec_waddr;

  mem_map_region_decode #(
    .ADDR_W (ADDR_W),
    .N_DEV  (N_DEV),
    .BASE   (DEV_BASE),
    .LIMIT  (DEV_LIMIT),
    .OFFS   (DEV_OFFS)
  ) u_decode (
    .addr_i      (gnt_addr_c),
    .hit_o       (dec_hit),
    .sel_o       (dec_sel),
    .word_addr_o (dec_waddr)
  );

  logic ro_viol_c;
  assign ro_viol_c = gnt_we_c & (|(dec_sel & DEV_RO));

  // Completion and read data of the currently selected device.
  logic              ready_c;
  logic [DATA_W-1:0] rdata_sel_c;

  always_comb begin
    ready_c     = |(dev_ready & dev_sel_q);
    rdata_sel_c = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_sel_q[i]) rdata_sel_c = rdata_sel_c | dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Hold off a new grant while an error ack is still on the port, since the
  // requester only sees it at the edge IDLE would sample the stale req.
  logic ack_busy_c;
  assign ack_busy_c = if_ack_q | d_ack_q;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_IF;
      rr_last_q   <= PORT_D;
      timer_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      dev_sel_q   <= '0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
    end else begin
      // Response signals are single-cycle pulses.
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;

      case (state_q)
        ST_IDLE: begin
          if (gnt_valid_c && !ack_busy_c) begin
            port_q  <= gnt_port_c;
            timer_q <= '0;
            if (dec_hit && !ro_viol_c) begin
              dev_sel_q   <= dec_sel;
              dev_we_q    <= gnt_we_c;
              dev_addr_q  <= dec_waddr;
              dev_wdata_q <= gnt_wdata_c;
              state_q     <= ST_ACCESS;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end

        ST_ACCESS: begin
          if (ready_c || (timer_q == TMR_W'(TIMEOUT - 1))) begin
            dev_sel_q   <= '0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
          end
          if (ready_c) begin
            if (port_q == PORT_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= rdata_sel_c;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= rdata_sel_c;
            end
            state_q <= ST_RESP;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q <= ST_ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end

        ST_RESP: begin
          rr_last_q <= port_q;
          state_q   <= ST_IDLE;
        end

        ST_ERR: begin
          if (port_q == PORT_IF) begin
            if_ack_q <= 1'b1;
            if_err_q <= 1'b1;
          end else begin
            d_ack_q <= 1'b1;
            d_err_q <= 1'b1;
          end
          rr_last_q <= port_q;
          state_q   <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign dev_sel   = dev_sel_q;
  assign dev_we    = dev_we_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_mem_map_bus_arbiter.sv
// Directed bench for mem_map_bus_arbiter. Inputs change 1 time unit after a
// rising edge; "cycle n" is observed n edges after the request was applied.
module tb_mem_map_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_DEV  = 4;

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0001;
  localparam logic [31:0] D2 = 32'hC2C2_0002;
  localparam logic [31:0] D3 = 32'hD3D3_0003;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    if_req;
  logic [ADDR_W-1:0]       if_addr;
  logic [DATA_W-1:0]       if_rdata;
  logic                    if_ack, if_err;
  logic                    d_req, d_we;
  logic [ADDR_W-1:0]       d_addr;
  logic [DATA_W-1:0]       d_wdata;
  logic [DATA_W-1:0]       d_rdata;
  logic                    d_ack, d_err;
  logic [N_DEV-1:0]        dev_sel;
  logic                    dev_we;
  logic [ADDR_W-1:0]       dev_addr;
  logic [DATA_W-1:0]       dev_wdata;
  logic [N_DEV*DATA_W-1:0] dev_rdata;
  logic [N_DEV-1:0]        dev_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_map_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_sel;
  int ack_cyc;
  logic err_seen;

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    dev_rdata = {D3, D2, D1, D0};
    dev_ready = '0;
    tick();
    tick();

    // Reset state
    chk("rst_if_ack",  64'(if_ack),   64'h0);
    chk("rst_d_ack",   64'(d_ack),    64'h0);
    chk("rst_dev_sel", 64'(dev_sel),  64'h0);
    chk("rst_dev_addr",64'(dev_addr), 64'h0);
    chk("rst_dev_we",  64'(dev_we),   64'h0);

    // Both ports from reset: fetch, data, fetch
    rst       = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0040_0000;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h1001_0004;
    dev_ready = 4'b1111;
    tick();
    chk("rr1_sel",  64'(dev_sel),  64'h2);
    chk("rr1_addr", 64'(dev_addr), 64'h0);
    tick();
    chk("rr1_if_ack", 64'(if_ack),   64'h1);
    chk("rr1_d_ack",  64'(d_ack),    64'h0);
    chk("rr1_rdata",  64'(if_rdata), 64'(D1));
    tick();
    chk("rr_idle_sel", 64'(dev_sel), 64'h0);
    tick();
    chk("rr2_sel",  64'(dev_sel),  64'h1);
    chk("rr2_addr", 64'(dev_addr), 64'h1);
    tick();
    chk("rr2_d_ack",  64'(d_ack),   64'h1);
    chk("rr2_if_ack", 64'(if_ack),  64'h0);
    chk("rr2_rdata",  64'(d_rdata), 64'(D0));
    tick();
    tick();
    chk("rr3_sel", 64'(dev_sel), 64'h2);
    tick();
    chk("rr3_if_ack", 64'(if_ack), 64'h1);
    chk("rr3_d_ack",  64'(d_ack),  64'h0);
    if_req    = 1'b0;
    d_req     = 1'b0;
    tick();

    // Data read, dev0 ready at once
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h1001_0010;
    dev_ready = 4'b0001;
    tick();
    chk("t1_sel",   64'(dev_sel),  64'h1);
    chk("t1_addr",  64'(dev_addr), 64'h4);
    chk("t1_we",    64'(dev_we),   64'h0);
    chk("t1_ack_c1",64'(d_ack),    64'h0);
    tick();
    chk("t1_ack",   64'(d_ack),   64'h1);
    chk("t1_err",   64'(d_err),   64'h0);
    chk("t1_rdata", 64'(d_rdata), 64'(D0));
    chk("t1_sel_c2",64'(dev_sel), 64'h0);
    d_req = 1'b0;
    tick();
    chk("t1_ack_c3", 64'(d_ack), 64'h0);

    // Fetch with three wait states on dev1
    if_req    = 1'b1;
    if_addr   = 32'h0040_0008;
    dev_ready = 4'b0000;
    tick();
    chk("t2_sel",  64'(dev_sel),  64'h2);
    chk("t2_addr", 64'(dev_addr), 64'h2);
    tick();
    tick();
    tick();
    chk("t2_ack_c4", 64'(if_ack), 64'h0);
    chk("t2_sel_c4", 64'(dev_sel), 64'h2);
    dev_ready = 4'b0010;
    tick();
    chk("t2_ack",   64'(if_ack),   64'h1);
    chk("t2_err",   64'(if_err),   64'h0);
    chk("t2_rdata", 64'(if_rdata), 64'(D1));
    if_req    = 1'b0;
    dev_ready = 4'b0000;
    tick();

    // Unmapped write
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2000_0000;
    d_wdata = 32'h1234_5678;
    tick();
    chk("t4_sel_c1", 64'(dev_sel), 64'h0);
    chk("t4_ack_c1", 64'(d_ack),   64'h0);
    tick();
    chk("t4_ack",   64'(d_ack),   64'h1);
    chk("t4_err",   64'(d_err),   64'h1);
    chk("t4_rdata", 64'(d_rdata), 64'h0);
    chk("t4_sel",   64'(dev_sel), 64'h0);
    d_req = 1'b0;
    tick();
    chk("t4_ack_c3", 64'(d_ack), 64'h0);

    // Write to dev3 that never completes
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h1001_0108;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t5_we",    64'(dev_we),    64'h1);
    chk("t5_wdata", 64'(dev_wdata), 64'hDEAD_BEEF);
    chk("t5_addr",  64'(dev_addr),  64'h0);
    n_sel    = (dev_sel == 4'b1000) ? 1 : 0;
    ack_cyc  = d_ack ? 1 : 0;
    err_seen = 1'b0;
    for (int c = 2; c <= 40 && ack_cyc == 0; c++) begin
      tick();
      if (dev_sel == 4'b1000) n_sel++;
      if (d_ack) begin
        ack_cyc  = c;
        err_seen = d_err;
      end
    end
    chk("t5_sel_cycles", 64'(n_sel),    64'd15);
    chk("t5_ack_cycle",  64'(ack_cyc),  64'd17);
    chk("t5_err",        64'(err_seen), 64'h1);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();

    // Reset in the middle of an access, then a fresh request
    d_req   = 1'b1;
    d_addr  = 32'h1001_0104;
    tick();
    chk("t6_sel",  64'(dev_sel),  64'h4);
    chk("t6_addr", 64'(dev_addr), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_sel",  64'(dev_sel),  64'h0);
    chk("t6_rst_ack",  64'(d_ack),    64'h0);
    chk("t6_rst_addr", 64'(dev_addr), 64'h0);
    rst       = 1'b0;
    d_addr    = 32'h1001_0100;
    dev_ready = 4'b0100;
    tick();
    chk("t6_new_sel",  64'(dev_sel),  64'h4);
    chk("t6_new_addr", 64'(dev_addr), 64'h0);
    tick();
    chk("t6_new_ack",   64'(d_ack),   64'h1);
    chk("t6_new_err",   64'(d_err),   64'h0);
    chk("t6_new_rdata", 64'(d_rdata), 64'(D2));
    d_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
